data_mem_ctrl: RTL and testbench
================================

# data_mem_ctrl

Parametrised data memory for the single-cycle CPU's load/store path. It adds byte/halfword/word access with sign or zero extension, a request/response handshake with configurable read latency, and error reporting for misaligned or out-of-range accesses. It sits between the CPU's memory-stage control and the data storage array, and replaces the fixed 32-word, word-only data memory.

## Interface
- DATA_WIDTH, 32: word width in bits; fixed at 32 in this generation, with 4 byte lanes.
- DEPTH, 256: number of words; power of two, 2..4096.
- READ_LATENCY, 1: cycles from read accept to read response; legal range 1..4.
- Clock  input  1  rising-edge clock.
- Reset_n  input  1  asynchronous, active-low reset.
- Req  input  1  request valid.
- Write  input  1  1 = store, 0 = load.
- Size  input  2  00 byte, 01 halfword, 10 word, 11 illegal.
- Unsigned  input  1  load zero-extends when 1 and sign-extends when 0; ignored for stores and word loads.
- Addr  input  32  byte address.
- DataIn  input  32  store data, right-justified (byte in [7:0], halfword in [15:0]).
- Ready  output  1  request accepted on a clock edge where Req && Ready.
- RespValid  output  1  one-cycle response pulse.
- DataOut  output  32  load result, valid while RespValid=1; 0 otherwise.
- Error  output  1  response is an error; valid while RespValid=1.

## Operation
Storage and reset:
- Array of DEPTH x 32 words. At simulation time 0, word i is initialised to i.
- Reset does not modify the array.

Addressing:
- Word index is Addr[log2(DEPTH)+1:2]. Lane is Addr[1:0], little-endian (lane 0 = bits [7:0]).
- Any set bit of Addr above the index field is an out-of-range access.

Error detection at accept:
- Error conditions: Size=11; halfword with Addr[0]=1; word with Addr[1:0]≠00; out of range.
- An errored access never writes the array. Its response is RespValid=1, Error=1, DataOut=0 one cycle after accept, regardless of READ_LATENCY.

Stores:
- Write occurs at the accept edge. Only the addressed lanes change: a byte store writes DataIn[7:0] into lane Addr[1:0]; a halfword store writes DataIn[15:0] into lanes Addr[1]*2 and Addr[1]*2+1; a word store writes all four lanes.
- Response is RespValid=1, Error=0, DataOut=0 in the next cycle.

Loads:
- Addr, Size and Unsigned are captured at accept. The word is read from the array at the final latency stage, so a store accepted in the immediately preceding cycle is visible.
- The selected byte or halfword is extended to 32 bits per Unsigned.

State machine:
- IDLE: Ready=1.
- WAIT: entered on a load accept when READ_LATENCY>1. Ready=0 and a counter is loaded with READ_LATENCY-1. Return to IDLE when the counter reaches 0; RespValid fires in that same cycle and Ready is already 1.
- Stores, errored accesses and loads with READ_LATENCY=1 stay in IDLE, giving one request per cycle.
- Req while Ready=0 is ignored; nothing is queued and there is no response.

## Timing
Reset:
- Reset_n low immediately forces Ready=1, RespValid=0, DataOut=0, Error=0, state IDLE, counter 0.
- A load pending at reset is discarded and produces no response. A store accepted at the same edge where reset deasserts is not guaranteed; the bench avoids that edge.

Latencies:
- Accept at edge k. Store and error responses appear in cycle k+1.
- Load response appears in cycle k+READ_LATENCY.
- RespValid is high for exactly one cycle per accepted request.

Back-to-back:
- A new request may be accepted in the same cycle its predecessor's RespValid is high.
- Responses never overlap and are returned in request order.

Outputs:
- DataOut and Error are registered and hold 0 whenever RespValid=0.

## Test plan
- Power-up word loads: reset, then load word 0x0C with READ_LATENCY=1 -> RespValid in the next cycle, DataOut=0x00000003, Error=0.
- Extension: store word 0x80FF7F01 to 0x10, then issue these loads:
  - byte 0x10 -> 0x00000001
  - signed byte 0x13 -> 0xFFFFFF80
  - unsigned byte 0x13 -> 0x00000080
  - signed half 0x12 -> 0xFFFF80FF
  - unsigned half 0x12 -> 0x000080FF
- Byte-lane store: byte store 0xAA to 0x15, then load word 0x14 -> 0x0000AA05. Issue the load in the cycle right after the store accept.
- Errors:
  - load word at 0x02 -> Error=1, DataOut=0.
  - halfword store at 0x11 -> Error=1; a subsequent word load at 0x10 still returns 0x80FF7F01.
  - Size=11 -> Error=1.
  - DEPTH=256, load word at 0x400 -> Error=1.
- Latency and handshake with READ_LATENCY=3:
  - Load accepted at edge k -> Ready=0 in cycles k+1 and k+2, RespValid=1 in cycle k+3 with Ready=1.
  - Req held high during the wait -> no extra accept and no extra response.
- Reset mid-operation with READ_LATENCY=3: accept a load, pulse Reset_n low one cycle later -> outputs are 0 immediately, no RespValid follows, Ready=1, and array contents are unchanged.

Source files
------------

// File: rtl/data_mem_ctrl.sv
`default_nettype none
// ---------------------------------------------------------------------------
// data_mem_ctrl : byte/half/word data memory, req/resp handshake, rev 1.0
// ---------------------------------------------------------------------------
module data_mem_ctrl #(
  parameter int DATA_WIDTH   = 32,
  parameter int DEPTH        = 256,
  parameter int READ_LATENCY = 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  req,
  input  logic                  write,
  input  logic [1:0]            size,
  input  logic                  load_unsigned,
  input  logic [31:0]           addr,
  input  logic [DATA_WIDTH-1:0] data_in,
  output logic                  ready,
  output logic                  resp_valid,
  output logic [DATA_WIDTH-1:0] data_out,
  output logic                  error
);

  localparam int IDX_W = $clog2(DEPTH);
  localparam int CNT_W = 2;
  localparam logic [CNT_W-1:0] C_CNT_LOAD = CNT_W'(READ_LATENCY - 1);
  localparam logic [1:0] C_SZ_BYTE = 2'b00;
  localparam logic [1:0] C_SZ_HALF = 2'b01;
  localparam logic [1:0] C_SZ_WORD = 2'b10;

  typedef enum logic [0:0] {S_IDLE = 1'b0, S_WAIT = 1'b1} state_t;

  state_t                state_q, state_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic                  ready_q, ready_d;
  logic                  resp_valid_q, resp_valid_d;
  logic                  error_q, error_d;
  logic [DATA_WIDTH-1:0] data_out_q, data_out_d;
  logic [IDX_W-1:0]      ld_idx_q, ld_idx_d;
  logic [1:0]            ld_lane_q, ld_lane_d;
  logic [1:0]            ld_size_q, ld_size_d;
  logic                  ld_uns_q, ld_uns_d;

  logic [DATA_WIDTH-1:0] mem_w [DEPTH];
  logic [IDX_W-1:0]      idx_w;
  logic [1:0]            lane_w;
  logic                  accept_w, err_w, wr_en_w;
  logic [3:0]            be_w;
  logic [DATA_WIDTH-1:0] wdata_w, wmask_w;
  logic [DATA_WIDTH-1:0] rd_word_w, rd_ext_w;
  logic [1:0]            rd_lane_w, rd_size_w;
  logic                  rd_uns_w;

  function automatic logic [DATA_WIDTH-1:0] load_extract(
    input logic [DATA_WIDTH-1:0] w,
    input logic [1:0]            lane,
    input logic [1:0]            sz,
    input logic                  uns
  );
    logic [7:0]  b;
    logic [15:0] h;
    b = w[{lane, 3'b000} +: 8];
    h = lane[1] ? w[31:16] : w[15:0];
    case (sz)
      C_SZ_BYTE: load_extract = {{24{b[7] & ~uns}}, b};
      C_SZ_HALF: load_extract = {{16{h[15] & ~uns}}, h};
      default:   load_extract = w;
    endcase
  endfunction

  assign idx_w    = addr[IDX_W+1:2];
  assign lane_w   = addr[1:0];
  assign accept_w = req && ready_q;
  assign wr_en_w  = accept_w && write && !err_w;

  always_comb begin
    err_w = (size == 2'b11)
         || (size == C_SZ_HALF && addr[0])
         || (size == C_SZ_WORD && addr[1:0] != 2'b00)
         || (|addr[31:IDX_W+2]);
  end

  // Store data is replicated across lanes; the byte enables pick the live ones.
  always_comb begin
    case (size)
      C_SZ_BYTE: begin
        be_w    = 4'b0001 << lane_w;
        wdata_w = {4{data_in[7:0]}};
      end
      C_SZ_HALF: begin
        be_w    = lane_w[1] ? 4'b1100 : 4'b0011;
        wdata_w = {2{data_in[15:0]}};
      end
      default: begin
        be_w    = 4'b1111;
        wdata_w = data_in;
      end
    endcase
  end

  assign wmask_w = {{8{be_w[3]}}, {8{be_w[2]}}, {8{be_w[1]}}, {8{be_w[0]}}};

  // Each word powers up holding its own index; reset never touches storage.
  for (genvar gi = 0; gi < DEPTH; gi++) begin : g_word
    localparam logic [IDX_W-1:0] C_IDX = IDX_W'(gi);
    logic [DATA_WIDTH-1:0] word_q = DATA_WIDTH'(gi);
    logic [DATA_WIDTH-1:0] word_d;
    always_comb begin
      word_d = word_q;
      if (wr_en_w && idx_w == C_IDX) begin
        word_d = (word_q & ~wmask_w) | (wdata_w & wmask_w);
      end
    end
    always @(posedge clk) word_q <= word_d;
    assign mem_w[gi] = word_q;
  end

  // The array is read at the final latency stage, from live or captured fields.
  always_comb begin
    if (state_q == S_WAIT) begin
      rd_word_w = mem_w[ld_idx_q];
      rd_lane_w = ld_lane_q;
      rd_size_w = ld_size_q;
      rd_uns_w  = ld_uns_q;
    end else begin
      rd_word_w = mem_w[idx_w];
      rd_lane_w = lane_w;
      rd_size_w = size;
      rd_uns_w  = load_unsigned;
    end
  end

  assign rd_ext_w = load_extract(rd_word_w, rd_lane_w, rd_size_w, rd_uns_w);

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    ready_d      = ready_q;
    resp_valid_d = 1'b0;
    error_d      = 1'b0;
    data_out_d   = '0;
    ld_idx_d     = ld_idx_q;
    ld_lane_d    = ld_lane_q;
    ld_size_d    = ld_size_q;
    ld_uns_d     = ld_uns_q;
    case (state_q)
      S_IDLE: begin
        if (accept_w) begin
          if (err_w) begin
            resp_valid_d = 1'b1;
            error_d      = 1'b1;
          end else if (write) begin
            resp_valid_d = 1'b1;
          end else if (READ_LATENCY == 1) begin
            resp_valid_d = 1'b1;
            data_out_d   = rd_ext_w;
          end else begin
            state_d   = S_WAIT;
            cnt_d     = C_CNT_LOAD;
            ready_d   = 1'b0;
            ld_idx_d  = idx_w;
            ld_lane_d = lane_w;
            ld_size_d = size;
            ld_uns_d  = load_unsigned;
          end
        end
      end
      S_WAIT: begin
        if (cnt_q == CNT_W'(1)) begin
          state_d      = S_IDLE;
          cnt_d        = '0;
          ready_d      = 1'b1;
          resp_valid_d = 1'b1;
          data_out_d   = rd_ext_w;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      cnt_q        <= '0;
      ready_q      <= 1'b1;
      resp_valid_q <= 1'b0;
      error_q      <= 1'b0;
      data_out_q   <= '0;
      ld_idx_q     <= '0;
      ld_lane_q    <= '0;
      ld_size_q    <= '0;
      ld_uns_q     <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      ready_q      <= ready_d;
      resp_valid_q <= resp_valid_d;
      error_q      <= error_d;
      data_out_q   <= data_out_d;
      ld_idx_q     <= ld_idx_d;
      ld_lane_q    <= ld_lane_d;
      ld_size_q    <= ld_size_d;
      ld_uns_q     <= ld_uns_d;
    end
  end

  assign ready      = ready_q;
  assign resp_valid = resp_valid_q;
  assign data_out   = data_out_q;
  assign error      = error_q;

endmodule
`default_nettype wire

// File: tb/tb_data_mem_ctrl.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_data_mem_ctrl : directed bench, READ_LATENCY=1 and READ_LATENCY=3 units
// ---------------------------------------------------------------------------
module tb_data_mem_ctrl;

  localparam logic [1:0] SZ_B = 2'b00;
  localparam logic [1:0] SZ_H = 2'b01;
  localparam logic [1:0] SZ_W = 2'b10;
  localparam logic [1:0] SZ_X = 2'b11;

  logic        clk = 1'b0;
  logic        rst1_n = 1'b1;
  logic        rst3_n = 1'b1;
  logic        req1 = 1'b0;
  logic        req3 = 1'b0;
  logic        write = 1'b0;
  logic [1:0]  size = 2'b00;
  logic        uns = 1'b0;
  logic [31:0] addr = '0;
  logic [31:0] din = '0;
  logic        ready1, rv1, er1, ready3, rv3, er3;
  logic [31:0] do1, do3;

  int checks = 0;
  int errors = 0;

  data_mem_ctrl #(.DATA_WIDTH(32), .DEPTH(256), .READ_LATENCY(1)) dut1 (
    .clk(clk), .rst_n(rst1_n), .req(req1), .write(write), .size(size),
    .load_unsigned(uns), .addr(addr), .data_in(din),
    .ready(ready1), .resp_valid(rv1), .data_out(do1), .error(er1)
  );

  data_mem_ctrl #(.DATA_WIDTH(32), .DEPTH(256), .READ_LATENCY(3)) dut3 (
    .clk(clk), .rst_n(rst3_n), .req(req3), .write(write), .size(size),
    .load_unsigned(uns), .addr(addr), .data_in(din),
    .ready(ready3), .resp_valid(rv3), .data_out(do3), .error(er3)
  );

  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL timeout reached before summary");
    $fatal(1);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic w, input logic [1:0] sz, input logic u,
                       input logic [31:0] a, input logic [31:0] d);
    write = w; size = sz; uns = u; addr = a; din = d;
  endtask

  task automatic test_reset();
    drive(1'b0, SZ_W, 1'b0, 32'h0, 32'h0);
    #1;
    rst1_n = 1'b0;
    rst3_n = 1'b0;
    tick();
    tick();
    checks++; if (ready1 !== 1'b1) begin errors++; $display("FAIL rst_ready1 got %b want 1", ready1); end
    checks++; if (rv1 !== 1'b0 || er1 !== 1'b0) begin errors++; $display("FAIL rst_rv_er1 got %b%b want 00", rv1, er1); end
    checks++; if (do1 !== 32'h0) begin errors++; $display("FAIL rst_do1 got %h want 0", do1); end
    checks++; if (ready3 !== 1'b1 || rv3 !== 1'b0 || do3 !== 32'h0) begin errors++; $display("FAIL rst_dut3 got rdy=%b rv=%b do=%h want 1 0 0", ready3, rv3, do3); end
    @(negedge clk);
    rst1_n = 1'b1;
    rst3_n = 1'b1;
    tick();
    checks++; if (ready1 !== 1'b1 || rv1 !== 1'b0) begin errors++; $display("FAIL rst_release got rdy=%b rv=%b want 1 0", ready1, rv1); end
  endtask

  task automatic test_power_up();
    drive(1'b0, SZ_W, 1'b0, 32'h0C, 32'h0);
    req1 = 1'b1;
    tick();
    req1 = 1'b0;
    checks++; if (rv1 !== 1'b1) begin errors++; $display("FAIL pwr_rv got %b want 1", rv1); end
    checks++; if (do1 !== 32'h00000003) begin errors++; $display("FAIL pwr_data got %h want 00000003", do1); end
    checks++; if (er1 !== 1'b0 || ready1 !== 1'b1) begin errors++; $display("FAIL pwr_er_rdy got %b%b want 01", er1, ready1); end
    tick();
    checks++; if (rv1 !== 1'b0 || do1 !== 32'h0) begin errors++; $display("FAIL pwr_pulse got rv=%b do=%h want 0 0", rv1, do1); end
  endtask

  task automatic test_extension();
    logic [1:0]  t_sz  [5] = '{SZ_B, SZ_B, SZ_B, SZ_H, SZ_H};
    logic        t_u   [5] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
    logic [31:0] t_a   [5] = '{32'h10, 32'h13, 32'h13, 32'h12, 32'h12};
    logic [31:0] t_exp [5] = '{32'h00000001, 32'hFFFFFF80, 32'h00000080, 32'hFFFF80FF, 32'h000080FF};
    drive(1'b1, SZ_W, 1'b0, 32'h10, 32'h80FF7F01);
    req1 = 1'b1;
    tick();
    checks++; if (rv1 !== 1'b1 || er1 !== 1'b0 || do1 !== 32'h0) begin errors++; $display("FAIL ext_store got rv=%b er=%b do=%h want 1 0 0", rv1, er1, do1); end
    for (int i = 0; i < 5; i++) begin
      drive(1'b0, t_sz[i], t_u[i], t_a[i], 32'h0);
      tick();
      checks++;
      if (rv1 !== 1'b1 || er1 !== 1'b0 || do1 !== t_exp[i]) begin
        errors++;
        $display("FAIL ext_load%0d got rv=%b er=%b do=%h want 1 0 %h", i, rv1, er1, do1, t_exp[i]);
      end
    end
    req1 = 1'b0;
    tick();
    checks++; if (rv1 !== 1'b0) begin errors++; $display("FAIL ext_idle got %b want 0", rv1); end
  endtask

  task automatic test_byte_lane();
    drive(1'b1, SZ_B, 1'b0, 32'h15, 32'h000000AA);
    req1 = 1'b1;
    tick();
    checks++; if (rv1 !== 1'b1 || er1 !== 1'b0) begin errors++; $display("FAIL lane_store got rv=%b er=%b want 1 0", rv1, er1); end
    drive(1'b0, SZ_W, 1'b0, 32'h14, 32'h0);
    tick();
    req1 = 1'b0;
    checks++; if (do1 !== 32'h0000AA05 || rv1 !== 1'b1) begin errors++; $display("FAIL lane_load got rv=%b do=%h want 1 0000aa05", rv1, do1); end
  endtask

  task automatic test_errors();
    logic        t_w  [4] = '{1'b0, 1'b1, 1'b0, 1'b0};
    logic [1:0]  t_sz [4] = '{SZ_W, SZ_H, SZ_X, SZ_W};
    logic [31:0] t_a  [4] = '{32'h02, 32'h11, 32'h10, 32'h400};
    req1 = 1'b1;
    for (int i = 0; i < 4; i++) begin
      drive(t_w[i], t_sz[i], 1'b0, t_a[i], 32'h0000BEEF);
      tick();
      checks++;
      if (rv1 !== 1'b1 || er1 !== 1'b1 || do1 !== 32'h0) begin
        errors++;
        $display("FAIL err%0d got rv=%b er=%b do=%h want 1 1 0", i, rv1, er1, do1);
      end
    end
    drive(1'b0, SZ_W, 1'b0, 32'h10, 32'h0);
    tick();
    req1 = 1'b0;
    checks++; if (er1 !== 1'b0 || do1 !== 32'h80FF7F01) begin errors++; $display("FAIL err_nowrite got er=%b do=%h want 0 80ff7f01", er1, do1); end
    drive(1'b0, SZ_W, 1'b0, 32'h02, 32'h0);
    req3 = 1'b1;
    tick();
    req3 = 1'b0;
    checks++; if (rv3 !== 1'b1 || er3 !== 1'b1 || ready3 !== 1'b1) begin errors++; $display("FAIL err_lat3 got rv=%b er=%b rdy=%b want 1 1 1", rv3, er3, ready3); end
    tick();
    checks++; if (rv3 !== 1'b0 || er3 !== 1'b0) begin errors++; $display("FAIL err_lat3_pulse got rv=%b er=%b want 0 0", rv3, er3); end
  endtask

  task automatic test_latency();
    drive(1'b0, SZ_W, 1'b0, 32'h0C, 32'h0);
    req3 = 1'b1;
    tick();
    checks++; if (ready3 !== 1'b0 || rv3 !== 1'b0) begin errors++; $display("FAIL lat_k1 got rdy=%b rv=%b want 0 0", ready3, rv3); end
    tick();
    checks++; if (ready3 !== 1'b0 || rv3 !== 1'b0 || do3 !== 32'h0) begin errors++; $display("FAIL lat_k2 got rdy=%b rv=%b do=%h want 0 0 0", ready3, rv3, do3); end
    tick();
    req3 = 1'b0;
    checks++; if (rv3 !== 1'b1 || ready3 !== 1'b1 || do3 !== 32'h3 || er3 !== 1'b0) begin errors++; $display("FAIL lat_k3 got rv=%b rdy=%b do=%h er=%b want 1 1 00000003 0", rv3, ready3, do3, er3); end
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++;
      if (rv3 !== 1'b0 || ready3 !== 1'b1) begin errors++; $display("FAIL lat_extra%0d got rv=%b rdy=%b want 0 1", i, rv3, ready3); end
    end
  endtask

  task automatic test_back_to_back();
    drive(1'b1, SZ_W, 1'b0, 32'h20, 32'h12345678);
    req3 = 1'b1;
    tick();
    checks++; if (rv3 !== 1'b1 || ready3 !== 1'b1) begin errors++; $display("FAIL b2b_store got rv=%b rdy=%b want 1 1", rv3, ready3); end
    drive(1'b0, SZ_W, 1'b0, 32'h20, 32'h0);
    tick();
    checks++; if (ready3 !== 1'b0 || rv3 !== 1'b0) begin errors++; $display("FAIL b2b_accept got rdy=%b rv=%b want 0 0", ready3, rv3); end
    tick();
    tick();
    checks++; if (rv3 !== 1'b1 || do3 !== 32'h12345678) begin errors++; $display("FAIL b2b_load1 got rv=%b do=%h want 1 12345678", rv3, do3); end
    drive(1'b0, SZ_H, 1'b1, 32'h22, 32'h0);
    tick();
    req3 = 1'b0;
    checks++; if (ready3 !== 1'b0 || rv3 !== 1'b0) begin errors++; $display("FAIL b2b_accept2 got rdy=%b rv=%b want 0 0", ready3, rv3); end
    tick();
    tick();
    checks++; if (rv3 !== 1'b1 || do3 !== 32'h00001234) begin errors++; $display("FAIL b2b_load2 got rv=%b do=%h want 1 00001234", rv3, do3); end
  endtask

  task automatic test_reset_mid();
    drive(1'b0, SZ_W, 1'b0, 32'h0C, 32'h0);
    req3 = 1'b1;
    tick();
    req3 = 1'b0;
    checks++; if (ready3 !== 1'b0) begin errors++; $display("FAIL mid_wait got rdy=%b want 0", ready3); end
    #1;
    rst3_n = 1'b0;
    #1;
    checks++; if (ready3 !== 1'b1 || rv3 !== 1'b0 || do3 !== 32'h0 || er3 !== 1'b0) begin errors++; $display("FAIL mid_async got rdy=%b rv=%b do=%h er=%b want 1 0 0 0", ready3, rv3, do3, er3); end
    @(posedge clk);
    @(negedge clk);
    rst3_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      checks++;
      if (rv3 !== 1'b0 || ready3 !== 1'b1) begin errors++; $display("FAIL mid_noresp%0d got rv=%b rdy=%b want 0 1", i, rv3, ready3); end
    end
    drive(1'b0, SZ_W, 1'b0, 32'h20, 32'h0);
    req3 = 1'b1;
    tick();
    req3 = 1'b0;
    tick();
    tick();
    checks++; if (rv3 !== 1'b1 || do3 !== 32'h12345678) begin errors++; $display("FAIL mid_array got rv=%b do=%h want 1 12345678", rv3, do3); end
  endtask

  initial begin
    test_reset();
    test_power_up();
    test_extension();
    test_byte_lane();
    test_errors();
    test_latency();
    test_back_to_back();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
